// File: rtl/msf_input_filter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// msf_input_filter
//
// Front end of the MSF time-signal receiver. The raw receiver output is
// synchronised, debounced by a saturating integrator with hysteresis, and
// its edges are measured against a 10 ms timebase. Pulse width and
// rise-to-rise period are judged every second; a run of good seconds
// declares lock, and a bad second or loss of signal drops it again.
//
// Optional feature: define MSF_FILTER_STATS_EN to count lock losses on
// err_count_o (saturating at 255). Without it err_count_o is tied to 0.
//
// Parameters
//   CLK_FREQ    clk_i frequency in Hz, multiple of 100
//   FILTER_LEN  integrator saturation value in clocks (2..255)
//   LOCK_COUNT  consecutive good seconds needed for lock (1..15)
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   data_i       raw receiver output, asynchronous, 1 = carrier off
//   data_o       filtered carrier-off level
//   rise_o       1-cycle pulse on each 0->1 change of data_o
//   fall_o       1-cycle pulse on each 1->0 change of data_o
//   lock_o       signal is valid MSF timing
//   error_o      1-cycle pulse on loss of lock
//   err_count_o  number of lock losses (MSF_FILTER_STATS_EN only)
// -----------------------------------------------------------------------------
module msf_input_filter #(
  parameter int CLK_FREQ   = 12500,
  parameter int FILTER_LEN = 16,
  parameter int LOCK_COUNT = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       data_i,
  output logic       data_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic       lock_o,
  output logic       error_o,
  output logic [7:0] err_count_o
);

  localparam int              DIV       = CLK_FREQ / 100;
  localparam int              PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(DIV - 1);
  localparam logic [7:0]      FLT_MAX   = 8'(FILTER_LEN);
  localparam logic [3:0]      LOCK_N    = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    SEARCH_REF = 2'd0,
    SEARCH     = 2'd1,
    LOCKED     = 2'd2
  } state_t;

  logic          r_sync_p0;
  logic          r_sync_p1;
  logic [7:0]    r_integ;
  logic          r_data;
  logic          r_rise;
  logic          r_fall;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_width;
  logic [7:0]    r_period;
  logic          r_width_ok;
  state_t        r_state;
  logic [3:0]    r_good;
  logic          r_lock;
  logic          r_err;

  logic          w_tick;
  logic          w_width_in_range;
  logic          w_good_sec;
  logic          w_timeout;

  // Stage p0/p1: two-flop synchroniser, then integrator and hysteresis.
  // The integrator never leaves 0..FLT_MAX, so equality tests act as bounds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
      r_integ   <= 8'd0;
      r_data    <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_sync_p0 <= data_i;
      r_sync_p1 <= r_sync_p0;
      if (r_sync_p1 && (r_integ != FLT_MAX)) begin
        r_integ <= r_integ + 8'd1;
      end else if (!r_sync_p1 && (r_integ != 8'd0)) begin
        r_integ <= r_integ - 8'd1;
      end
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if ((r_integ == FLT_MAX) && !r_data) begin
        r_data <= 1'b1;
        r_rise <= 1'b1;
      end else if ((r_integ == 8'd0) && r_data) begin
        r_data <= 1'b0;
        r_fall <= 1'b1;
      end
    end
  end

  assign w_tick = (r_presc == PRESC_MAX);

  // 10 ms timebase.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Stage p2: width/period measurement. A rise starts a new second and
  // clears width_ok, so a second with no fall is always judged bad.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_width    <= 8'd0;
      r_period   <= 8'd0;
      r_width_ok <= 1'b0;
    end else if (r_rise) begin
      r_width    <= 8'd0;
      r_period   <= 8'd0;
      r_width_ok <= 1'b0;
    end else begin
      if (w_tick && (r_period != 8'hFF)) begin
        r_period <= r_period + 8'd1;
      end
      if (w_tick && r_data && (r_width != 8'hFF)) begin
        r_width <= r_width + 8'd1;
      end
      if (r_fall) begin
        r_width_ok <= w_width_in_range;
      end
    end
  end

  assign w_width_in_range = (r_width >= 8'd8) && (r_width <= 8'd55);
  assign w_good_sec       = (r_period >= 8'd95) && (r_period <= 8'd105) && r_width_ok;
  assign w_timeout        = (r_period == 8'd200);

  // Lock state machine. rise takes priority over timeout in every state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= SEARCH_REF;
      r_good  <= 4'd0;
      r_lock  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        SEARCH_REF: begin
          // first edge only sets the reference; it is not judged
          if (r_rise) begin
            r_state <= SEARCH;
            r_good  <= 4'd0;
          end
        end
        SEARCH: begin
          if (r_rise) begin
            if (w_good_sec) begin
              r_good <= r_good + 4'd1;
              if ((r_good + 4'd1) == LOCK_N) begin
                r_state <= LOCKED;
                r_lock  <= 1'b1;
              end
            end else begin
              r_good <= 4'd0;
            end
          end else if (w_timeout) begin
            r_state <= SEARCH_REF;
            r_good  <= 4'd0;
          end
        end
        LOCKED: begin
          if (r_rise) begin
            if (!w_good_sec) begin
              r_state <= SEARCH;
              r_good  <= 4'd0;
              r_lock  <= 1'b0;
              r_err   <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state <= SEARCH_REF;
            r_good  <= 4'd0;
            r_lock  <= 1'b0;
            r_err   <= 1'b1;
          end
        end
        default: begin
          r_state <= SEARCH_REF;
          r_good  <= 4'd0;
          r_lock  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MSF_FILTER_STATS_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_count <= 8'h00;
    end else if (r_err && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count_o = r_err_count;
`else
  assign err_count_o = 8'h00;
`endif

  assign data_o  = r_data;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;
  assign lock_o  = r_lock;
  assign error_o = r_err;

endmodule

// File: tb/tb_msf_input_filter.sv
`timescale 1ns/1ps
// Self-checking bench for msf_input_filter. A 1 kHz clock makes one MSF
// second 1000 clocks and one timebase tick 10 clocks. The reference model
// keeps the integrator as a plain count and judges seconds from the
// timestamps of filtered edges, counting timebase ticks arithmetically.
module tb_msf_input_filter;

  localparam int TB_CLK  = 1000;
  localparam int TB_FLEN = 16;
  localparam int TB_LOCK = 5;
  localparam int DIV     = TB_CLK / 100;

  logic       clk;
  logic       rst;
  logic       data_i;
  logic       data_o;
  logic       rise_o;
  logic       fall_o;
  logic       lock_o;
  logic       error_o;
  logic [7:0] err_count_o;

  msf_input_filter #(
    .CLK_FREQ  (TB_CLK),
    .FILTER_LEN(TB_FLEN),
    .LOCK_COUNT(TB_LOCK)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .data_i     (data_i),
    .data_o     (data_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .lock_o     (lock_o),
    .error_o    (error_o),
    .err_count_o(err_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_bad;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_c;                       // index of the next clock edge since reset
  int m_s1, m_s2, m_integ;
  int m_data, m_rise, m_fall;
  int m_lock, m_err, m_errcnt;
  int m_state;                   // 0 reference search, 1 search, 2 locked
  int m_good, m_wok;
  int m_lrise;                   // edge index where the last rise was consumed

  // number of 10 ms ticks at edges strictly between edge a and edge b
  function automatic int ticks_in(input int a, input int b);
    return (b / DIV) - ((a + 1) / DIV);
  endfunction

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    m_c = 0; m_s1 = 0; m_s2 = 0; m_integ = 0;
    m_data = 0; m_rise = 0; m_fall = 0;
    m_lock = 0; m_err = 0; m_errcnt = 0;
    m_state = 0; m_good = 0; m_wok = 0; m_lrise = -1;
  endtask

  task automatic model_step(input int d);
    int per;
    int wid;
    int new_err;
    int new_data;
    per = sat255(ticks_in(m_lrise, m_c));
    new_err = 0;
    if (m_rise != 0) begin
      if (m_state == 0) begin
        m_state = 1;
        m_good  = 0;
      end else begin
        if (per >= 95 && per <= 105 && m_wok != 0) begin
          if (m_state == 1) begin
            m_good++;
            if (m_good == TB_LOCK) m_state = 2;
          end
        end else begin
          if (m_state == 2) new_err = 1;
          m_state = 1;
          m_good  = 0;
        end
      end
      m_lrise = m_c;
      m_wok   = 0;
    end else begin
      if (m_fall != 0) begin
        wid   = sat255(ticks_in(m_lrise, m_c));
        m_wok = (wid >= 8 && wid <= 55) ? 1 : 0;
      end
      if (m_state != 0 && per == 200) begin
        if (m_state == 2) new_err = 1;
        m_state = 0;
        m_good  = 0;
      end
    end
`ifdef MSF_FILTER_STATS_EN
    if (m_err != 0 && m_errcnt < 255) m_errcnt++;
`endif
    m_err  = new_err;
    m_lock = (m_state == 2) ? 1 : 0;
    if (m_integ == TB_FLEN)  new_data = 1;
    else if (m_integ == 0)   new_data = 0;
    else                     new_data = m_data;
    m_rise = (new_data == 1 && m_data == 0) ? 1 : 0;
    m_fall = (new_data == 0 && m_data == 1) ? 1 : 0;
    m_data = new_data;
    if (m_s2 != 0 && m_integ < TB_FLEN)    m_integ++;
    else if (m_s2 == 0 && m_integ > 0)     m_integ--;
    m_s2 = m_s1;
    m_s1 = d;
    m_c++;
  endtask

  // ---------------- per-window observation ----------------
  int n_rise, n_errp, saw_lock, rise_at_lock, rise_at_unlock, prev_lock;

  task automatic win_clear();
    n_rise = 0; n_errp = 0; saw_lock = 0;
    rise_at_lock = -1; rise_at_unlock = -1;
  endtask

  // Drive one clock of data_i (called just after a falling edge), then
  // compare every output at the next falling edge.
  task automatic drive_cycle(input int d);
    data_i = (d != 0);
    model_step(d);
    @(posedge clk);
    @(negedge clk);
    check("data_o",  data_o,      m_data);
    check("rise_o",  rise_o,      m_rise);
    check("fall_o",  fall_o,      m_fall);
    check("lock_o",  lock_o,      m_lock);
    check("error_o", error_o,     m_err);
    check("err_cnt", err_count_o, m_errcnt);
    if (rise_o) n_rise++;
    if (error_o) n_errp++;
    if (lock_o && !saw_lock) begin
      saw_lock = 1;
      rise_at_lock = n_rise;
    end
    if (!lock_o && prev_lock != 0 && rise_at_unlock < 0) rise_at_unlock = n_rise;
    prev_lock = lock_o;
  endtask

  task automatic second(input int per, input int wid);
    for (int i = 0; i < wid; i++) drive_cycle(1);
    for (int i = 0; i < per - wid; i++) drive_cycle(0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  data_o,      0);
    check({tag, "_rise"},  rise_o,      0);
    check({tag, "_fall"},  fall_o,      0);
    check({tag, "_lock"},  lock_o,      0);
    check({tag, "_error"}, error_o,     0);
    check({tag, "_cnt"},   err_count_o, 0);
  endtask

  int exp_cnt1, exp_cnt2;

  initial begin
    n_chk = 0;
    n_bad = 0;
    prev_lock = 0;
`ifdef MSF_FILTER_STATS_EN
    exp_cnt1 = 1;
    exp_cnt2 = 2;
`else
    exp_cnt1 = 0;
    exp_cnt2 = 0;
`endif
    rst    = 1'b1;
    data_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst0");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    win_clear();

    // idle, then a 10-cycle glitch that must be absorbed
    for (int i = 0; i < 50; i++) drive_cycle(0);
    for (int i = 0; i < 10; i++) drive_cycle(1);
    for (int i = 0; i < 60; i++) drive_cycle(0);
    check("glitch_rise", n_rise, 0);
    check("glitch_data", data_o, 0);

    // lock acquisition: 7 seconds of 100 ms pulses
    win_clear();
    for (int s = 0; s < 7; s++) second(1000, 100);
    check("lock_rises", rise_at_lock, 6);
    check("lock_errs",  n_errp, 0);
    check("lock_state", lock_o, 1);

    // one 700 ms pulse while locked, then recover
    win_clear();
    second(1000, 700);
    for (int s = 0; s < 7; s++) second(1000, 100);
    check("badw_unlock_rise", rise_at_unlock, 2);
    check("badw_errs",  n_errp, 1);
    check("badw_cnt",   err_count_o, exp_cnt1);
    check("badw_relock", lock_o, 1);

    // signal loss while locked
    win_clear();
    second(1000, 100);
    for (int i = 0; i < 2100; i++) drive_cycle(0);
    check("loss_errs", n_errp, 1);
    check("loss_lock", lock_o, 0);
    check("loss_cnt",  err_count_o, exp_cnt2);

    // period tolerance: 0.94 s never locks, 1.05 s with 500 ms pulses does
    win_clear();
    for (int s = 0; s < 8; s++) second(940, 100);
    check("p094_lock", saw_lock, 0);
    win_clear();
    for (int s = 0; s < 7; s++) second(1050, 500);
    check("p105_lock", lock_o, 1);
    check("p105_errs", n_errp, 0);

    // asynchronous reset in the middle of a pulse while locked
    check("pre_rst_lock", lock_o, 1);
    for (int i = 0; i < 60; i++) drive_cycle(1);
    check("pre_rst_data", data_o, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst1");
    data_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hold_err", error_o, 0);
    rst = 1'b0;
    model_reset();
    prev_lock = 0;
    win_clear();
    for (int s = 0; s < 7; s++) second(1000, 100);
    check("relock_rises", rise_at_lock, 6);
    check("relock_errs",  n_errp, 0);
    check("relock_cnt",   err_count_o, 0);

    // randomized seconds with occasional short glitches
    for (int s = 0; s < 6; s++) begin
      int per;
      int wid;
      int gpos;
      int glen;
      per  = $urandom_range(1100, 900);
      wid  = $urandom_range(750, 30);
      gpos = $urandom_range(per - wid - 20, 10);
      glen = ($urandom_range(2, 0) == 0) ? $urandom_range(8, 1) : 0;
      for (int i = 0; i < wid; i++) drive_cycle(1);
      for (int i = 0; i < per - wid; i++)
        drive_cycle((i >= gpos && i < gpos + glen) ? 1 : 0);
    end
    for (int i = 0; i < 200; i++) drive_cycle($urandom_range(1, 0));
    for (int i = 0; i < 100; i++) drive_cycle(0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/msf_input_filter.md
MSF_INPUT_FILTER -- requirements
Module: msf_input_filter

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 12500, meaning the clk_i frequency in Hz, which SHALL be a multiple of 100.
REQ-002 The block SHALL have parameter FILTER_LEN, default 16, meaning the integrator saturation value in clocks, range 2..255.
REQ-003 The block SHALL have parameter LOCK_COUNT, default 5, meaning the number of consecutive good seconds required to declare lock, range 1..15.
REQ-004 The block SHALL have port clk_i, input, width 1, meaning the single clock.
REQ-005 The block SHALL have port rst_i, input, width 1, meaning reset, asynchronous, active-high.
REQ-006 The block SHALL have port data_i, input, width 1, meaning the raw receiver output, asynchronous, with 1 = carrier off.
REQ-007 The block SHALL have port data_o, input-referenced output, width 1, meaning the filtered carrier-off level, feeding bit_sampler.
REQ-008 The block SHALL have port rise_o, output, width 1, meaning a 1-cycle pulse on each 0->1 transition of data_o.
REQ-009 The block SHALL have port fall_o, output, width 1, meaning a 1-cycle pulse on each 1->0 transition of data_o.
REQ-010 The block SHALL have port lock_o, output, width 1, meaning the signal is valid MSF timing.
REQ-011 The block SHALL have port error_o, output, width 1, meaning a 1-cycle pulse on loss of lock.
REQ-012 The block SHALL have port err_count_o, output, width 8, meaning the count of lock losses (see Configuration).

Function
REQ-013 data_i SHALL pass through a 2-flop synchronizer before any other use, giving 2 cycles of latency.
REQ-014 The integrator SHALL be an unsigned counter in 0..FILTER_LEN that increments when the synced input is 1 and below FILTER_LEN, decrements when the synced input is 0 and above 0, and otherwise holds.
REQ-015 data_o SHALL be set to 1 in the cycle after the integrator reaches FILTER_LEN and cleared in the cycle after it reaches 0, and SHALL otherwise hold its value (hysteresis).
REQ-016 rise_o and fall_o SHALL be registered and asserted in the same cycle that data_o changes, and SHALL never both be high.
REQ-017 A prescaler SHALL generate a tick every CLK_FREQ/100 clocks (10 ms).
REQ-018 width_cnt (8 bit, saturating at 255) SHALL clear on rise_o and increment on each tick while data_o = 1.
REQ-019 period_cnt (8 bit, saturating at 255) SHALL clear on rise_o and increment on each tick otherwise.
REQ-020 On fall_o, width_ok SHALL be latched as 1 if 8 <= width_cnt <= 55, and as 0 otherwise.
REQ-021 A second SHALL be good when, on rise_o, 95 <= period_cnt <= 105 and width_ok = 1.
REQ-022 The FSM SHALL have states SEARCH_REF, SEARCH and LOCKED, and a good counter good_cnt (4 bit).
REQ-023 In SEARCH_REF, rise_o SHALL move the FSM to SEARCH with good_cnt = 0, and this first edge SHALL NOT be judged.
REQ-024 In SEARCH, on rise_o, a good second SHALL increment good_cnt and a bad second SHALL set good_cnt = 0.
REQ-025 When good_cnt reaches LOCK_COUNT, the FSM SHALL move to LOCKED and lock_o SHALL be 1 from the next cycle.
REQ-026 In LOCKED, a bad second SHALL move the FSM to SEARCH, clear good_cnt, deassert lock_o and pulse error_o for 1 cycle.
REQ-027 In SEARCH or LOCKED, a timeout (period_cnt = 200 without rise_o) SHALL move the FSM to SEARCH_REF, clear good_cnt, and pulse error_o only if the FSM was LOCKED.
REQ-028 When rise_o and the timeout condition occur in the same cycle, rise_o SHALL take priority.
REQ-029 width_ok SHALL be cleared on every rise_o, so that a missing fall before the next rise gives a bad second.

Reset
REQ-030 Assertion of rst_i SHALL immediately set the synchronizer, integrator, prescaler, width_cnt, period_cnt, width_ok and good_cnt to 0.
REQ-031 Assertion of rst_i SHALL set the FSM to SEARCH_REF.
REQ-032 Assertion of rst_i SHALL set data_o, rise_o, fall_o, lock_o and error_o to 0, and err_count_o to 8'h00.
REQ-033 Reset asserted mid-pulse SHALL discard the measurement in progress.
REQ-034 No error_o pulse SHALL be produced on reset.

Configuration
REQ-035 With macro MSF_FILTER_STATS_EN defined, err_count_o SHALL increment on each error_o pulse and saturate at 255.
REQ-036 Without MSF_FILTER_STATS_EN, err_count_o SHALL be tied to 8'h00 and no counter logic SHALL be present.

Verification
REQ-037 The bench SHALL cover the glitch case: a 10-cycle high glitch with FILTER_LEN = 16 SHALL cause no change on data_o and no rise_o.
REQ-038 The bench SHALL cover lock acquisition: 7 seconds of 100 ms carrier-off pulses every 1.000 s SHALL give lock_o = 1 after the 6th rise (1 reference edge + 5 good seconds), with error_o never pulsed.
REQ-039 The bench SHALL cover a bad width while locked: one 700 ms pulse SHALL cause lock_o to drop at the next rise, error_o to pulse once, and err_count_o to be 1 (macro on) or 0 (macro off).
REQ-040 The bench SHALL cover signal loss while locked: holding data_i = 0 for 2.1 s SHALL give an error_o pulse at period_cnt = 200, put the FSM in SEARCH_REF, and keep lock_o = 0.
REQ-041 The bench SHALL cover period tolerance: seconds of 0.94 s SHALL never lock, and seconds of 1.05 s with 500 ms pulses SHALL lock.
REQ-042 The bench SHALL cover reset: asserting rst_i during LOCKED SHALL force all outputs to 0 asynchronously with no error_o pulse, and relock SHALL take a further 6 rises.
